// File: rtl/risc16_mem_responder_if.sv
// Bus bundle between the RISC16 core/host side and the memory responder.
// Groups the fetch port (i_*), data port (d_*), host load port (ld_*),
// run control (halt_req/cpu_rst), load statistics and debug read-back.
//   master : core + host side, drives addresses, enables, write data, load words
//   slave  : memory responder, drives read data, ld_ready, cpu_rst, stats, dbg_data
interface risc16_mem_responder_if;
  logic [15:0] i_addr;
  logic        i_oe;
  logic [15:0] i_dout;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [15:0] d_dout;
  logic [15:0] d_din;
  logic [1:0]  d_we;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        halt_req;
  logic        cpu_rst;
  logic [15:0] ld_count;
  logic [15:0] ld_sum;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_data;

  modport master (
    output i_addr, i_oe, d_addr, d_oe, d_din, d_we,
    output ld_valid, ld_addr, ld_data, ld_last, halt_req, dbg_addr,
    input  i_dout, d_dout, ld_ready, cpu_rst, ld_count, ld_sum, dbg_data
  );

  modport slave (
    input  i_addr, i_oe, d_addr, d_oe, d_din, d_we,
    input  ld_valid, ld_addr, ld_data, ld_last, halt_req, dbg_addr,
    output i_dout, d_dout, ld_ready, cpu_rst, ld_count, ld_sum, dbg_data
  );
endinterface

// File: rtl/risc16_mem_responder.sv
// RISC16 memory responder: one word-organised RAM serving the core's fetch
// and data ports with same-cycle reads and big-endian byte-lane writes, plus a
// host load port and a LOAD -> START -> RUN boot FSM that keeps the core in
// reset while a program is written.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : risc16_mem_responder_if.slave (fetch, data, load, control, debug)
module risc16_mem_responder #(
  parameter int ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  risc16_mem_responder_if.slave        bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;

  // Word indices: byte address bit 0 and bits above ADDR_W are dropped, so
  // higher addresses alias onto the RAM.
  logic [ADDR_W-1:0] i_idx, d_idx, ld_idx, dbg_idx;
  assign i_idx   = bus.i_addr[ADDR_W:1];
  assign d_idx   = bus.d_addr[ADDR_W:1];
  assign ld_idx  = bus.ld_addr[ADDR_W:1];
  assign dbg_idx = bus.dbg_addr[ADDR_W:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[15:ADDR_W+1], bus.i_addr[0],
                              bus.d_addr[15:ADDR_W+1], bus.d_addr[0],
                              bus.ld_addr[15:ADDR_W+1], bus.ld_addr[0],
                              bus.dbg_addr[15:ADDR_W+1], bus.dbg_addr[0]};

  logic [15:0] mem [2**ADDR_W];

  logic load_xfer;
  assign load_xfer = (state == LOAD) && bus.ld_valid;

  // Boot FSM and load statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      bus.ld_count <= '0;
      bus.ld_sum   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update reading
      // the pre-edge values, so ordering inside this block does not matter.
      unique case (state)
        LOAD: begin
          if (bus.ld_valid) begin
            bus.ld_count <= bus.ld_count + 16'd1;
            bus.ld_sum   <= bus.ld_sum + bus.ld_data;
            if (bus.ld_last) state <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (bus.halt_req) begin
            state        <= LOAD;
            bus.ld_count <= '0;
            bus.ld_sum   <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Handshake and core reset are pure decodes of the state register.
  assign bus.ld_ready = (state == LOAD);
  assign bus.cpu_rst  = (state != RUN);

  // RAM write port. Host loads write whole words; the core writes byte lanes
  // only while running (including the cycle a halt is requested).
  // NOTE: the RAM has no reset so it maps onto block memory and keeps its
  // contents across rst.
  always_ff @(posedge clk) begin
    if (load_xfer) begin
      mem[ld_idx] <= bus.ld_data;
    end else if (state == RUN) begin
      if (bus.d_we[0]) mem[d_idx][15:8] <= bus.d_din[15:8];
      if (bus.d_we[1]) mem[d_idx][7:0]  <= bus.d_din[7:0];
    end
  end

  // Same-cycle reads; a word written this cycle still reads its old value.
  assign bus.i_dout = (state == RUN && bus.i_oe) ? mem[i_idx] : 16'h0000;
  assign bus.d_dout = (state == RUN && bus.d_oe) ? mem[d_idx] : 16'h0000;

  // Debug read-back, one cycle of latency, active in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.dbg_data <= '0;
    else     bus.dbg_data <= mem[dbg_idx];
  end

endmodule

// File: tb/tb_risc16_mem_responder.sv
module tb_risc16_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  risc16_mem_responder_if bus ();

  risc16_mem_responder #(.ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_addr = '0; bus.i_oe = 1'b0;
    bus.d_addr = '0; bus.d_oe = 1'b0; bus.d_din = '0; bus.d_we = 2'b00;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.halt_req = 1'b0; bus.dbg_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst got=%b exp=1", bus.cpu_rst); end
    n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got=%b exp=1", bus.ld_ready); end
    n_checks++; if (bus.ld_count !== 16'h0000) begin n_fail++; $display("FAIL reset_ld_count got=%h exp=0000", bus.ld_count); end
    n_checks++; if (bus.ld_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_ld_sum got=%h exp=0000", bus.ld_sum); end
    n_checks++; if (bus.dbg_data !== 16'h0000) begin n_fail++; $display("FAIL reset_dbg_data got=%h exp=0000", bus.dbg_data); end
  endtask

  task automatic test_load_boot();
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0000; bus.ld_data = 16'h1111; bus.ld_last = 1'b0;
    tick();
    n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_stay_in_load ld_ready got=%b exp=1", bus.ld_ready); end
    bus.ld_addr = 16'h0002; bus.ld_data = 16'h2222; bus.ld_last = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    #1;
    n_checks++; if (bus.ld_count !== 16'd2) begin n_fail++; $display("FAIL load_count got=%0d exp=2", bus.ld_count); end
    n_checks++; if (bus.ld_sum !== 16'h3333) begin n_fail++; $display("FAIL load_sum got=%h exp=3333", bus.ld_sum); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL start_cpu_rst got=%b exp=1", bus.cpu_rst); end
    n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL start_ld_ready got=%b exp=0", bus.ld_ready); end
    tick();
    n_checks++; if (bus.cpu_rst !== 1'b0) begin n_fail++; $display("FAIL run_cpu_rst got=%b exp=0", bus.cpu_rst); end
  endtask

  task automatic test_fetch();
    bus.i_addr = 16'h0002; bus.i_oe = 1'b1;
    #1;
    n_checks++; if (bus.i_dout !== 16'h2222) begin n_fail++; $display("FAIL fetch_word got=%h exp=2222", bus.i_dout); end
    bus.i_addr = 16'h0001;
    #1;
    n_checks++; if (bus.i_dout !== 16'h1111) begin n_fail++; $display("FAIL fetch_odd_addr got=%h exp=1111", bus.i_dout); end
    bus.i_addr = 16'h0002; bus.d_addr = 16'h2002; bus.d_oe = 1'b1;
    #1;
    n_checks++; if (bus.d_dout !== 16'h2222) begin n_fail++; $display("FAIL data_alias_read got=%h exp=2222", bus.d_dout); end
    n_checks++; if (bus.i_dout !== 16'h2222) begin n_fail++; $display("FAIL fetch_same_word got=%h exp=2222", bus.i_dout); end
    bus.i_oe = 1'b0; bus.d_oe = 1'b0;
    #1;
    n_checks++; if (bus.i_dout !== 16'h0000) begin n_fail++; $display("FAIL fetch_disabled got=%h exp=0000", bus.i_dout); end
    n_checks++; if (bus.d_dout !== 16'h0000) begin n_fail++; $display("FAIL data_disabled got=%h exp=0000", bus.d_dout); end
  endtask

  task automatic test_byte_lanes();
    bus.d_addr = 16'h0004; bus.d_oe = 1'b1;
    bus.d_din = 16'h1234; bus.d_we = 2'b11;
    tick();
    bus.d_din = 16'hAB00; bus.d_we = 2'b01;
    #1;
    n_checks++; if (bus.d_dout !== 16'h1234) begin n_fail++; $display("FAIL read_during_write_old got=%h exp=1234", bus.d_dout); end
    tick();
    bus.d_we = 2'b00;
    #1;
    n_checks++; if (bus.d_dout !== 16'hAB34) begin n_fail++; $display("FAIL we01_high_byte got=%h exp=AB34", bus.d_dout); end
    bus.d_din = 16'h00CD; bus.d_we = 2'b10;
    tick();
    bus.d_we = 2'b00;
    #1;
    n_checks++; if (bus.d_dout !== 16'hABCD) begin n_fail++; $display("FAIL we10_low_byte got=%h exp=ABCD", bus.d_dout); end
    bus.d_din = 16'h5555; bus.d_we = 2'b00;
    tick();
    n_checks++; if (bus.d_dout !== 16'hABCD) begin n_fail++; $display("FAIL we00_no_write got=%h exp=ABCD", bus.d_dout); end
    bus.d_din = 16'hBEEF; bus.d_we = 2'b11;
    tick();
    bus.d_we = 2'b00; bus.dbg_addr = 16'h0004;
    #1;
    n_checks++; if (bus.d_dout !== 16'hBEEF) begin n_fail++; $display("FAIL we11_full_word got=%h exp=BEEF", bus.d_dout); end
    tick();
    n_checks++; if (bus.dbg_data !== 16'hBEEF) begin n_fail++; $display("FAIL dbg_run_read got=%h exp=BEEF", bus.dbg_data); end
    bus.d_oe = 1'b0;
  endtask

  task automatic test_halt();
    bus.halt_req = 1'b1; bus.d_addr = 16'h0006; bus.d_din = 16'h5A5A; bus.d_we = 2'b11;
    bus.i_addr = 16'h0000; bus.i_oe = 1'b1;
    tick();
    bus.halt_req = 1'b0; bus.d_we = 2'b00; bus.dbg_addr = 16'h0006;
    #1;
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL halt_cpu_rst got=%b exp=1", bus.cpu_rst); end
    n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ld_ready got=%b exp=1", bus.ld_ready); end
    n_checks++; if (bus.ld_count !== 16'h0000) begin n_fail++; $display("FAIL halt_ld_count got=%h exp=0000", bus.ld_count); end
    n_checks++; if (bus.ld_sum !== 16'h0000) begin n_fail++; $display("FAIL halt_ld_sum got=%h exp=0000", bus.ld_sum); end
    n_checks++; if (bus.i_dout !== 16'h0000) begin n_fail++; $display("FAIL halt_i_dout got=%h exp=0000", bus.i_dout); end
    tick();
    n_checks++; if (bus.dbg_data !== 16'h5A5A) begin n_fail++; $display("FAIL halt_write_commit got=%h exp=5A5A", bus.dbg_data); end
    bus.i_oe = 1'b0;
  endtask

  task automatic test_load_mode_guards();
    // Core write and halt_req both ignored while loading.
    bus.d_addr = 16'h0000; bus.d_din = 16'hDEAD; bus.d_we = 2'b11; bus.halt_req = 1'b1;
    bus.dbg_addr = 16'h0000;
    tick();
    bus.d_we = 2'b00; bus.halt_req = 1'b0;
    tick();
    n_checks++; if (bus.dbg_data !== 16'h1111) begin n_fail++; $display("FAIL load_core_write_ignored got=%h exp=1111", bus.dbg_data); end
    n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_halt_ignored ld_ready got=%b exp=1", bus.ld_ready); end
  endtask

  task automatic test_wrap_and_async_reset();
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h2000; bus.ld_data = 16'h7777; bus.ld_last = 1'b0;
    bus.dbg_addr = 16'h0000;
    tick();
    bus.ld_valid = 1'b0;
    #1;
    n_checks++; if (bus.dbg_data !== 16'h1111) begin n_fail++; $display("FAIL dbg_latency_old got=%h exp=1111", bus.dbg_data); end
    n_checks++; if (bus.ld_count !== 16'd1) begin n_fail++; $display("FAIL wrap_ld_count got=%0d exp=1", bus.ld_count); end
    n_checks++; if (bus.ld_sum !== 16'h7777) begin n_fail++; $display("FAIL wrap_ld_sum got=%h exp=7777", bus.ld_sum); end
    tick();
    n_checks++; if (bus.dbg_data !== 16'h7777) begin n_fail++; $display("FAIL wrap_dbg_read got=%h exp=7777", bus.dbg_data); end
    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ld_count !== 16'h0000) begin n_fail++; $display("FAIL async_rst_ld_count got=%h exp=0000", bus.ld_count); end
    n_checks++; if (bus.ld_sum !== 16'h0000) begin n_fail++; $display("FAIL async_rst_ld_sum got=%h exp=0000", bus.ld_sum); end
    n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ld_ready got=%b exp=1", bus.ld_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.dbg_addr = 16'h0002;
    tick();
    n_checks++; if (bus.dbg_data !== 16'h2222) begin n_fail++; $display("FAIL ram_kept_after_rst got=%h exp=2222", bus.dbg_data); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL post_rst_cpu_rst got=%b exp=1", bus.cpu_rst); end
  endtask

  initial begin
    test_reset();
    test_load_boot();
    test_fetch();
    test_byte_lanes();
    test_halt();
    test_load_mode_guards();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
